jtag_dma_cmd_chain: RTL and testbench
=====================================

Name: jtag_dma_cmd_chain

Overview:
- Parametrised successor of the JTAG user-chain command register.
- Shifts an (OPC_W+DATA_W)-bit command in from JTDI during user-chain shift, decodes it on JUPDATE, and maintains address, byte-enable, burst and pointer registers plus a local word buffer.
- Launches DMA read/write bursts through a start/busy/done handshake.
- Adds over the previous chain:
  - capture-phase readback
  - auto-incrementing buffer pointer
  - DMA read direction
  - sticky status/error register
  - DMA timeout

Parameters:
DATA_W, 32, payload/readback width
OPC_W, 4, opcode width; must be at least 4
BUF_DEPTH, 16, buffer words; power of 2; PTR_W = log2(BUF_DEPTH)
BURST_W, 8, burst-length register width
BE_W, 4, byte-enable width
TIMEOUT, 1024, max JTCK cycles per DMA transfer; 0 disables the timeout

Ports:
JTCK  in  1  sole clock; all state updates on the rising edge
JRST  in  1  synchronous active-high reset
JTDI  in  1  serial data in
JCE1  in  1  chain enable
JSHIFT  in  1  shift phase qualifier
JUPDATE  in  1  update strobe
JTD1  out  1  serial data out = shreg[0]
dma_start  out  1  one-cycle launch pulse
dma_dir  out  1  1 = write (buffer to bus), 0 = read
dma_addr  out  DATA_W  bus start address
dma_burst  out  BURST_W  burst length in words
dma_be  out  BE_W  byte enables
dma_busy  in  1  engine busy
dma_done  in  1  one-cycle completion pulse
dma_buf_addr  in  PTR_W  engine buffer index
dma_buf_wdata  in  DATA_W  engine write data
dma_buf_we  in  1  engine buffer write
dma_buf_rdata  out  DATA_W  buf[dma_buf_addr], registered, 1-cycle latency

Behaviour:
- Shift:
  - JCE1&JSHIFT: shreg <= {JTDI, shreg[W-1:1]}, W = OPC_W+DATA_W.
  - JCE1&!JSHIFT (capture): shreg <= zero-extended rb_reg.
  - Otherwise shreg holds.
- Decode happens on the first JUPDATE-high cycle (rising-edge detect); an extended JUPDATE does not re-execute. opc = shreg[OPC_W-1:0], pl = shreg[W-1:OPC_W]. Effects are visible the next cycle.
- Opcodes:
  - 0 NOP.
  - 1 addr <= pl.
  - 2 be <= pl[BE_W-1:0].
  - 3 burst <= pl[BURST_W-1:0].
  - 4/5/6 rb_reg <= addr/be/burst.
  - 7 ptr <= pl[PTR_W-1:0].
  - 8 buf[ptr] <= pl; ptr++.
  - 9 rb_reg <= buf[ptr]; ptr++.
  - A launch write; B launch read.
  - C rb_reg <= status.
  - D clears status bits 1..5.
  - E/F set err_opcode, no other effect.
- ptr wraps from BUF_DEPTH-1 to 0.
- FSM states IDLE, WAIT, RUN:
  - IDLE -> WAIT on a legal launch; dma_start is high for the single cycle after the decode edge.
  - WAIT -> RUN when dma_busy=1.
  - WAIT or RUN -> IDLE on dma_done; this also sets the sticky done bit.
  - Timeout counter resets on leaving IDLE. When it reaches TIMEOUT in WAIT/RUN: err_timeout set, FSM -> IDLE.
- Launch is legal only if FSM=IDLE, dma_busy=0 and 1 <= burst <= BUF_DEPTH.
  - FSM!=IDLE or dma_busy=1: err_busy set, no start.
  - burst = 0 or burst > BUF_DEPTH: err_burst set, no start.
- When FSM!=IDLE, opcodes 1/2/3/7/8 are rejected (err_busy set, no register change). Reads and status still execute.
- dma_addr/dma_burst/dma_be/dma_dir drive the registered values continuously.
- Engine buffer writes are always honoured; JTAG buffer writes cannot collide because they are rejected while the FSM is busy.
- Status word: [0] busy (FSM!=IDLE), [1] done, [2] err_busy, [3] err_burst, [4] err_opcode, [5] err_timeout, [8+PTR_W-1:8] ptr, remaining bits 0.
- A dma_done arriving while in IDLE is ignored (done is not set).
- Reset (JRST), including mid-transfer:
  - shreg, rb_reg, addr, ptr, status, counter = 0.
  - be = all ones; burst = 1.
  - FSM = IDLE; dma_start = 0; JTD1 = 0; dma_buf_rdata = 0.
  - Buffer contents are undefined.

Test Plan:
- Reset, then shift 0x3_0000_0000 | opc 4 (RD_ADDR), update, capture, shift out → 32 bits 0x00000000; repeat with opc 5 → 0x0000000F.
- Command pl=0x55555555 opc 1, then opc 4 readback → JTD1 serially emits 0x55555555 LSB first.
- opc 7 pl=15; opc 8 pl=0xABCDEF0 then pl=0x1234567 (ptr wraps); opc 7 pl=15; opc 9 ×2 → readbacks 0xABCDEF0, 0x1234567; dma_buf_addr=0 yields 0x1234567 after one cycle.
- burst=4, opc A with dma_busy=1 → no dma_start, status=0x0004; opc D → status bit2 clears; dma_busy=0, opc A → single dma_start pulse, dma_dir=1; busy=1 then done → status bit1=1, busy=0.
- burst=0 then opc B → err_burst (status bit3); opc E → err_opcode (bit4); TIMEOUT=8 bench variant: launch, never busy → IDLE after 8 cycles, bit5 set.
- Launch, assert JRST during RUN → next cycle FSM IDLE, status 0, dma_start low, be=0xF, burst=1.

Source files
------------

// File: rtl/jtag_dma_cmd_chain.sv
// JTAG user-chain command register with buffer, readback and status, driving a
// DMA engine through a start/busy/done handshake with an optional timeout.
module jtag_dma_cmd_chain #(
   parameter int DATA_W    = 32,
   parameter int OPC_W     = 4,
   parameter int BUF_DEPTH = 16,
   parameter int BURST_W   = 8,
   parameter int BE_W      = 4,
   parameter int TIMEOUT   = 1024,
   localparam int PTR_W    = $clog2(BUF_DEPTH)
) (
   input  logic               JTCK,
   input  logic               JRST,
   input  logic               JTDI,
   input  logic               JCE1,
   input  logic               JSHIFT,
   input  logic               JUPDATE,
   output logic               JTD1,
   output logic               dma_start,
   output logic               dma_dir,
   output logic [DATA_W-1:0]  dma_addr,
   output logic [BURST_W-1:0] dma_burst,
   output logic [BE_W-1:0]    dma_be,
   input  logic               dma_busy,
   input  logic               dma_done,
   input  logic [PTR_W-1:0]   dma_buf_addr,
   input  logic [DATA_W-1:0]  dma_buf_wdata,
   input  logic               dma_buf_we,
   output logic [DATA_W-1:0]  dma_buf_rdata
);

   localparam int W     = OPC_W + DATA_W;
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;

   localparam logic [OPC_W-1:0] OP_NOP      = OPC_W'(4'h0);
   localparam logic [OPC_W-1:0] OP_ADDR     = OPC_W'(4'h1);
   localparam logic [OPC_W-1:0] OP_BE       = OPC_W'(4'h2);
   localparam logic [OPC_W-1:0] OP_BURST    = OPC_W'(4'h3);
   localparam logic [OPC_W-1:0] OP_RD_ADDR  = OPC_W'(4'h4);
   localparam logic [OPC_W-1:0] OP_RD_BE    = OPC_W'(4'h5);
   localparam logic [OPC_W-1:0] OP_RD_BURST = OPC_W'(4'h6);
   localparam logic [OPC_W-1:0] OP_PTR      = OPC_W'(4'h7);
   localparam logic [OPC_W-1:0] OP_BUF_WR   = OPC_W'(4'h8);
   localparam logic [OPC_W-1:0] OP_BUF_RD   = OPC_W'(4'h9);
   localparam logic [OPC_W-1:0] OP_LAUNCH_W = OPC_W'(4'hA);
   localparam logic [OPC_W-1:0] OP_LAUNCH_R = OPC_W'(4'hB);
   localparam logic [OPC_W-1:0] OP_STATUS   = OPC_W'(4'hC);
   localparam logic [OPC_W-1:0] OP_CLEAR    = OPC_W'(4'hD);

   logic [W-1:0]       shreg;
   logic               upd_q;
   logic [DATA_W-1:0]  rb_reg;
   logic [DATA_W-1:0]  addr_q;
   logic [BE_W-1:0]    be_q;
   logic [BURST_W-1:0] burst_q;
   logic [PTR_W-1:0]   ptr;
   logic [1:0]         state;
   logic [CNT_W-1:0]   cnt;
   logic               start_q;
   logic               dir_q;
   logic               st_done, err_busy, err_burst, err_opcode, err_timeout;
   logic [DATA_W-1:0]  rdata_q;
   logic [DATA_W-1:0]  mem [BUF_DEPTH];

   logic               decode, idle, burst_ok, timeout_hit;
   logic [OPC_W-1:0]   opc;
   logic [DATA_W-1:0]  pl;
   logic [DATA_W-1:0]  status_word;
   logic               wr_addr, wr_be, wr_burst, wr_ptr, wr_buf, inc_ptr;
   logic               rb_load, launch, clr_status;
   logic               set_busy, set_burst, set_opc;
   logic [DATA_W-1:0]  rb_next;

   // Only the first cycle of a JUPDATE pulse executes the command.
   assign decode      = JUPDATE & ~upd_q;
   assign opc         = shreg[OPC_W-1:0];
   assign pl          = shreg[W-1:OPC_W];
   assign idle        = (state == ST_IDLE);
   assign burst_ok    = (burst_q != '0) && (32'(burst_q) <= BUF_DEPTH);
   assign timeout_hit = (TIMEOUT != 0) && !idle && (cnt == CNT_W'(TIMEOUT - 1));

   always_comb begin
      status_word             = '0;
      status_word[0]          = !idle;
      status_word[1]          = st_done;
      status_word[2]          = err_busy;
      status_word[3]          = err_burst;
      status_word[4]          = err_opcode;
      status_word[5]          = err_timeout;
      status_word[8 +: PTR_W] = ptr;
   end

   // NOTE: every output of a combinational block gets a default first so no
   // path through the case leaves it unassigned and infers a latch.
   always_comb begin
      wr_addr    = 1'b0;
      wr_be      = 1'b0;
      wr_burst   = 1'b0;
      wr_ptr     = 1'b0;
      wr_buf     = 1'b0;
      inc_ptr    = 1'b0;
      rb_load    = 1'b0;
      rb_next    = '0;
      launch     = 1'b0;
      clr_status = 1'b0;
      set_busy   = 1'b0;
      set_burst  = 1'b0;
      set_opc    = 1'b0;
      if (decode) begin
         case (opc)
            OP_NOP: ;
            OP_ADDR:     if (idle) wr_addr  = 1'b1; else set_busy = 1'b1;
            OP_BE:       if (idle) wr_be    = 1'b1; else set_busy = 1'b1;
            OP_BURST:    if (idle) wr_burst = 1'b1; else set_busy = 1'b1;
            OP_PTR:      if (idle) wr_ptr   = 1'b1; else set_busy = 1'b1;
            OP_BUF_WR: begin
               if (idle) begin
                  wr_buf  = 1'b1;
                  inc_ptr = 1'b1;
               end else begin
                  set_busy = 1'b1;
               end
            end
            OP_RD_ADDR:  begin rb_load = 1'b1; rb_next = addr_q;           end
            OP_RD_BE:    begin rb_load = 1'b1; rb_next = DATA_W'(be_q);    end
            OP_RD_BURST: begin rb_load = 1'b1; rb_next = DATA_W'(burst_q); end
            OP_BUF_RD: begin
               rb_load = 1'b1;
               rb_next = mem[ptr];
               inc_ptr = 1'b1;
            end
            OP_LAUNCH_W, OP_LAUNCH_R: begin
               if (!idle || dma_busy) set_busy  = 1'b1;
               else if (!burst_ok)    set_burst = 1'b1;
               else                   launch    = 1'b1;
            end
            OP_STATUS:   begin rb_load = 1'b1; rb_next = status_word; end
            OP_CLEAR:    clr_status = 1'b1;
            default:     set_opc    = 1'b1;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge JTCK) begin
      if (JRST) begin
         shreg       <= '0;
         upd_q       <= 1'b0;
         rb_reg      <= '0;
         addr_q      <= '0;
         be_q        <= '1;
         burst_q     <= BURST_W'(1);
         ptr         <= '0;
         state       <= ST_IDLE;
         cnt         <= '0;
         start_q     <= 1'b0;
         dir_q       <= 1'b0;
         st_done     <= 1'b0;
         err_busy    <= 1'b0;
         err_burst   <= 1'b0;
         err_opcode  <= 1'b0;
         err_timeout <= 1'b0;
         rdata_q     <= '0;
      end else begin
         upd_q   <= JUPDATE;
         rdata_q <= mem[dma_buf_addr];
         start_q <= launch;

         if (JCE1 && JSHIFT)  shreg <= {JTDI, shreg[W-1:1]};
         else if (JCE1)       shreg <= W'(rb_reg);

         if (rb_load)  rb_reg  <= rb_next;
         if (wr_addr)  addr_q  <= pl;
         if (wr_be)    be_q    <= pl[BE_W-1:0];
         if (wr_burst) burst_q <= pl[BURST_W-1:0];
         if (wr_ptr)        ptr <= pl[PTR_W-1:0];
         else if (inc_ptr)  ptr <= ptr + 1'b1;
         if (launch)   dir_q   <= (opc == OP_LAUNCH_W);

         cnt <= idle ? '0 : cnt + 1'b1;

         case (state)
            ST_IDLE: if (launch) state <= ST_WAIT;
            ST_WAIT: begin
               if (dma_done || timeout_hit) state <= ST_IDLE;
               else if (dma_busy)           state <= ST_RUN;
            end
            ST_RUN:  if (dma_done || timeout_hit) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase

         // Sets follow the clear so an event coinciding with a clear survives.
         if (clr_status) begin
            st_done     <= 1'b0;
            err_busy    <= 1'b0;
            err_burst   <= 1'b0;
            err_opcode  <= 1'b0;
            err_timeout <= 1'b0;
         end
         if (dma_done && !idle)        st_done     <= 1'b1;
         if (set_busy)                 err_busy    <= 1'b1;
         if (set_burst)                err_burst   <= 1'b1;
         if (set_opc)                  err_opcode  <= 1'b1;
         if (timeout_hit && !dma_done) err_timeout <= 1'b1;
      end
   end

   // NOTE: the buffer is deliberately left out of reset; its contents are
   // undefined after JRST and a reset would turn the RAM into flops.
   always_ff @(posedge JTCK) begin
      if (wr_buf)     mem[ptr]          <= pl;
      if (dma_buf_we) mem[dma_buf_addr] <= dma_buf_wdata;
   end

   assign JTD1          = shreg[0];
   assign dma_start     = start_q;
   assign dma_dir       = dir_q;
   assign dma_addr      = addr_q;
   assign dma_burst     = burst_q;
   assign dma_be        = be_q;
   assign dma_buf_rdata = rdata_q;

endmodule

// File: tb/tb_jtag_dma_cmd_chain.sv
// Directed self-checking bench for jtag_dma_cmd_chain, built with TIMEOUT=8 so
// the timeout path is reachable in a few cycles.
module tb_jtag_dma_cmd_chain;

   localparam int DATA_W = 32, OPC_W = 4, BUF_DEPTH = 16, BURST_W = 8, BE_W = 4;
   localparam int TIMEOUT = 8, PTR_W = 4, W = OPC_W + DATA_W;

   logic               jtck = 1'b0;
   logic               jrst, jtdi, jce1, jshift, jupdate;
   logic               jtd1, dma_start, dma_dir;
   logic [DATA_W-1:0]  dma_addr, dma_buf_wdata, dma_buf_rdata;
   logic [BURST_W-1:0] dma_burst;
   logic [BE_W-1:0]    dma_be;
   logic               dma_busy, dma_done, dma_buf_we;
   logic [PTR_W-1:0]   dma_buf_addr;

   int checks = 0, errors = 0, start_cnt = 0, s0;
   logic [DATA_W-1:0] v;

   jtag_dma_cmd_chain #(
      .DATA_W(DATA_W), .OPC_W(OPC_W), .BUF_DEPTH(BUF_DEPTH),
      .BURST_W(BURST_W), .BE_W(BE_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .JTCK(jtck), .JRST(jrst), .JTDI(jtdi), .JCE1(jce1), .JSHIFT(jshift),
      .JUPDATE(jupdate), .JTD1(jtd1), .dma_start(dma_start), .dma_dir(dma_dir),
      .dma_addr(dma_addr), .dma_burst(dma_burst), .dma_be(dma_be),
      .dma_busy(dma_busy), .dma_done(dma_done), .dma_buf_addr(dma_buf_addr),
      .dma_buf_wdata(dma_buf_wdata), .dma_buf_we(dma_buf_we),
      .dma_buf_rdata(dma_buf_rdata)
   );

   always #5 jtck = ~jtck;

   // Counts cycles in which dma_start is high; a proper pulse adds exactly one.
   always @(posedge jtck) if (dma_start === 1'b1) start_cnt++;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge jtck);
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic shift_cmd(input logic [3:0] opc, input logic [31:0] pl,
                            output logic [W-1:0] so);
      logic [W-1:0] c;
      c      = {pl, opc};
      jce1   = 1'b1;
      jshift = 1'b1;
      for (int i = 0; i < W; i++) begin
         so[i] = jtd1;
         jtdi  = c[i];
         tick();
      end
      jce1   = 1'b0;
      jshift = 1'b0;
      jtdi   = 1'b0;
   endtask

   // JUPDATE is held two cycles so a repeated execution would be visible.
   task automatic update();
      jupdate = 1'b1;
      tick(2);
      jupdate = 1'b0;
      tick();
   endtask

   task automatic cmd(input logic [3:0] opc, input logic [31:0] pl);
      logic [W-1:0] so;
      shift_cmd(opc, pl, so);
      update();
   endtask

   task automatic readback(input logic [3:0] opc, output logic [31:0] val);
      logic [W-1:0] so;
      cmd(opc, 32'h0);
      jce1 = 1'b1;
      tick();
      jce1 = 1'b0;
      shift_cmd(4'h0, 32'h0, so);
      check("rb_pad", 64'(so[W-1:DATA_W]), 64'h0);
      val = so[DATA_W-1:0];
   endtask

   initial begin
      jrst = 1'b1; jtdi = 1'b0; jce1 = 1'b0; jshift = 1'b0; jupdate = 1'b0;
      dma_busy = 1'b0; dma_done = 1'b0; dma_buf_we = 1'b0;
      dma_buf_addr = '0; dma_buf_wdata = '0;
      tick(3);
      check("rst_jtd1",  64'(jtd1), 64'h0);
      check("rst_start", 64'(dma_start), 64'h0);
      check("rst_be",    64'(dma_be), 64'hF);
      check("rst_burst", 64'(dma_burst), 64'h1);
      check("rst_addr",  64'(dma_addr), 64'h0);
      check("rst_rdata", 64'(dma_buf_rdata), 64'h0);
      jrst = 1'b0;
      tick();

      // Register readback after reset and after an address write.
      readback(4'h4, v); check("rd_addr_rst", 64'(v), 64'h0);
      readback(4'h5, v); check("rd_be_rst", 64'(v), 64'hF);
      cmd(4'h1, 32'h5555_5555);
      check("dma_addr", 64'(dma_addr), 64'h5555_5555);
      readback(4'h4, v); check("rd_addr", 64'(v), 64'h5555_5555);

      // Buffer writes with pointer wrap, then JTAG and engine reads.
      cmd(4'h7, 32'd15);
      cmd(4'h8, 32'h0ABC_DEF0);
      cmd(4'h8, 32'h0123_4567);
      readback(4'hC, v); check("status_ptr", 64'(v), 64'h100);
      cmd(4'h7, 32'd15);
      readback(4'h9, v); check("buf_rd15", 64'(v), 64'h0ABC_DEF0);
      readback(4'h9, v); check("buf_rd0", 64'(v), 64'h0123_4567);
      dma_buf_addr = 4'd0;
      tick();
      check("eng_rdata0", 64'(dma_buf_rdata), 64'h0123_4567);
      dma_buf_addr = 4'd3; dma_buf_wdata = 32'hDEAD_BEEF; dma_buf_we = 1'b1;
      tick();
      dma_buf_we = 1'b0;
      cmd(4'h7, 32'd3);
      readback(4'h9, v); check("eng_wr_rd", 64'(v), 64'hDEAD_BEEF);

      // Launch refused while the engine reports busy, then a legal write launch.
      cmd(4'h7, 32'd0);
      cmd(4'h3, 32'd4);
      dma_busy = 1'b1;
      s0 = start_cnt;
      cmd(4'hA, 32'h0);
      check("no_start_busy", 64'(start_cnt - s0), 64'h0);
      readback(4'hC, v); check("status_errbusy", 64'(v), 64'h004);
      cmd(4'hD, 32'h0);
      readback(4'hC, v); check("status_clr", 64'(v), 64'h000);
      dma_busy = 1'b0;
      s0 = start_cnt;
      cmd(4'hA, 32'h0);
      check("start_pulse", 64'(start_cnt - s0), 64'h1);
      check("dir_write", 64'(dma_dir), 64'h1);
      check("burst4", 64'(dma_burst), 64'h4);
      dma_busy = 1'b1; tick();
      dma_done = 1'b1; dma_busy = 1'b0; tick();
      dma_done = 1'b0; tick();
      readback(4'hC, v); check("status_done", 64'(v), 64'h002);

      // Stray done in IDLE, burst limits, illegal opcode.
      cmd(4'hD, 32'h0);
      dma_done = 1'b1; tick(); dma_done = 1'b0; tick();
      readback(4'hC, v); check("idle_done_ign", 64'(v), 64'h000);
      s0 = start_cnt;
      cmd(4'h3, 32'd0);
      cmd(4'hB, 32'h0);
      readback(4'hC, v); check("err_burst0", 64'(v), 64'h008);
      cmd(4'hE, 32'h0);
      readback(4'hC, v); check("err_opcode", 64'(v), 64'h018);
      cmd(4'hD, 32'h0);
      cmd(4'h3, 32'd17);
      cmd(4'hB, 32'h0);
      readback(4'hC, v); check("err_burst17", 64'(v), 64'h008);
      check("no_start_burst", 64'(start_cnt - s0), 64'h0);

      // Largest legal burst, read direction, engine never responds.
      cmd(4'h3, 32'd16);
      cmd(4'hB, 32'h0);
      check("start_rd", 64'(start_cnt - s0), 64'h1);
      check("dir_read", 64'(dma_dir), 64'h0);
      tick(10);
      readback(4'hC, v); check("err_timeout", 64'(v), 64'h028);

      // Reset in the middle of a transfer.
      cmd(4'hD, 32'h0);
      cmd(4'h3, 32'd2);
      cmd(4'hA, 32'h0);
      dma_busy = 1'b1; tick();
      jrst = 1'b1; tick();
      check("mid_rst_start", 64'(dma_start), 64'h0);
      check("mid_rst_be",    64'(dma_be), 64'hF);
      check("mid_rst_burst", 64'(dma_burst), 64'h1);
      check("mid_rst_rdata", 64'(dma_buf_rdata), 64'h0);
      jrst = 1'b0; dma_busy = 1'b0; tick();
      readback(4'hC, v); check("mid_rst_status", 64'(v), 64'h000);
      readback(4'h6, v); check("mid_rst_rdburst", 64'(v), 64'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
